// File: rtl/ssp_slv_frontend.sv
// SPI-slave (mode 0, MSB first) front end feeding the SSP_UART register port.
// Build option: define SSP_FRAME_ERR_EN to enable the Frame_Err framing-error strobe.
module ssp_slv_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_LEN   = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        SSEL_n,
  input  logic        SCK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE,
  input  logic [11:0] SSP_DO,
  output logic        SSP_SSEL,
  output logic        SSP_SCK,
  output logic [2:0]  SSP_RA,
  output logic        SSP_WnR,
  output logic        SSP_En,
  output logic        SSP_EOC,
  output logic [11:0] SSP_DI,
  output logic        Frame_Err
);

  if (FRAME_LEN != 16) begin : g_bad_frame_len
    $error("ssp_slv_frontend: FRAME_LEN must be 16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("ssp_slv_frontend: SYNC_STAGES must be 2..4");
  end

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] ssel_sync_reg, sck_sync_reg, mosi_sync_reg;
  logic        sck_dly_reg;
  state_t      state_reg;
  logic [4:0]  bit_cnt_reg;
  logic [10:0] rx_reg;
  logic [10:0] tx_reg;

  logic        sel_now, sck_s, mosi_s, sck_rise, sck_fall;
  logic [11:0] rx_next;

  // SSEL_n resets to the deselected level so leaving reset never looks like a select.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ssel_sync_reg <= '1;
      sck_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      sck_dly_reg   <= 1'b0;
    end else begin
      ssel_sync_reg <= {ssel_sync_reg[SYNC_STAGES-2:0], SSEL_n};
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], SCK};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
      sck_dly_reg   <= sck_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sel_now  = ~ssel_sync_reg[SYNC_STAGES-1];
  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_reg;
  assign sck_fall = ~sck_s & sck_dly_reg;
  assign rx_next  = {rx_reg, mosi_s};
  assign SSP_SCK  = sck_dly_reg;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      rx_reg      <= '0;
      tx_reg      <= '0;
      MISO        <= 1'b0;
      MISO_OE     <= 1'b0;
      SSP_SSEL    <= 1'b0;
      SSP_RA      <= '0;
      SSP_WnR     <= 1'b0;
      SSP_En      <= 1'b0;
      SSP_EOC     <= 1'b0;
      SSP_DI      <= '0;
    end else begin
      SSP_SSEL <= sel_now;
      MISO_OE  <= sel_now;
      SSP_EOC  <= 1'b0;
      case (state_reg)
        IDLE: begin
          bit_cnt_reg <= '0;
          rx_reg      <= '0;
          MISO        <= 1'b0;
          if (sel_now) state_reg <= HDR;
        end
        HDR: begin
          if (!sel_now) begin
            state_reg <= IDLE;
            SSP_En    <= 1'b0;
          end else if (sck_rise) begin
            rx_reg      <= rx_next[10:0];
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd2) SSP_RA <= rx_next[2:0];
            if (bit_cnt_reg == 5'd3) begin
              SSP_WnR   <= mosi_s;
              SSP_En    <= 1'b1;
              tx_reg    <= SSP_DO[10:0];
              MISO      <= SSP_DO[11];
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (!sel_now) begin
            state_reg <= IDLE;
            SSP_En    <= 1'b0;
            MISO      <= 1'b0;
          end else if (sck_rise) begin
            rx_reg      <= rx_next[10:0];
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'(FRAME_LEN - 1)) begin
              SSP_DI    <= rx_next;
              SSP_EOC   <= 1'b1;
              SSP_En    <= 1'b0;
              MISO      <= 1'b0;
              state_reg <= DONE;
            end
          end else if (sck_fall && bit_cnt_reg != 5'd4) begin
            // The fall right after the header keeps bit 11 up for the master's rise #5.
            MISO   <= tx_reg[10];
            tx_reg <= {tx_reg[9:0], 1'b0};
          end
        end
        DONE: begin
          MISO <= 1'b0;
          if (!sel_now) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SSP_FRAME_ERR_EN
  logic frame_err_reg, extra_seen_reg;
  logic abort_evt, extra_evt;

  assign abort_evt = (state_reg == HDR || state_reg == DATA) && !sel_now;
  assign extra_evt = (state_reg == DONE) && sel_now && sck_rise;

  // Only the first surplus SCK rise in DONE is reported.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      frame_err_reg  <= 1'b0;
      extra_seen_reg <= 1'b0;
    end else begin
      frame_err_reg  <= abort_evt | (extra_evt & ~extra_seen_reg);
      extra_seen_reg <= (state_reg == DONE) ? (extra_seen_reg | extra_evt) : 1'b0;
    end
  end

  assign Frame_Err = frame_err_reg;
`else
  assign Frame_Err = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_slv_frontend.sv
// Self-checking bench for ssp_slv_frontend: vector table, corner sequences, random frames.
module tb_ssp_slv_frontend;
  localparam int SYNC_STAGES = 2;
  localparam int HALF = 8;
`ifdef SSP_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        Clk = 1'b0, Rst = 1'b0, SSEL_n = 1'b1, SCK = 1'b0, MOSI = 1'b0;
  logic [11:0] SSP_DO = '0;
  logic        MISO, MISO_OE, SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC, Frame_Err;
  logic [2:0]  SSP_RA;
  logic [11:0] SSP_DI;

  always #5 Clk = ~Clk;

  ssp_slv_frontend #(.SYNC_STAGES(SYNC_STAGES), .FRAME_LEN(16)) dut (
    .Clk(Clk), .Rst(Rst), .SSEL_n(SSEL_n), .SCK(SCK), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .SSP_DO(SSP_DO), .SSP_SSEL(SSP_SSEL),
    .SSP_SCK(SSP_SCK), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR), .SSP_En(SSP_En),
    .SSP_EOC(SSP_EOC), .SSP_DI(SSP_DI), .Frame_Err(Frame_Err)
  );

  int checks = 0, errors = 0;
  int eoc_cnt = 0, ferr_cnt = 0;

  always @(negedge Clk) begin
    if (SSP_EOC === 1'b1) eoc_cnt++;
    if (Frame_Err === 1'b1) ferr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  logic [17:0] miso_cap, en_cap;
  logic        oe_mid;
  int          d_eoc, d_ferr, drop_cyc;

  // Master side: bits beyond 16 are sent as 1s; MISO/En are sampled just before each rise.
  task automatic run_frame(input logic [15:0] w, input int nbits, input logic [11:0] do_val,
                           input bit keep_sel);
    int e0, f0;
    e0 = eoc_cnt; f0 = ferr_cnt;
    miso_cap = '0; en_cap = '0; oe_mid = 1'b0; drop_cyc = 0;
    SSP_DO = do_val;
    SSEL_n = 1'b0;
    wait_clk(HALF);
    for (int k = 1; k <= nbits; k++) begin
      SCK  = 1'b0;
      MOSI = (k <= 16) ? w[16-k] : 1'b1;
      wait_clk(HALF);
      miso_cap[k-1] = MISO;
      en_cap[k-1]   = SSP_En;
      if (k == 1) oe_mid = MISO_OE;
      SCK = 1'b1;
      wait_clk(HALF);
    end
    SCK = 1'b0;
    wait_clk(HALF);
    if (!keep_sel) begin
      SSEL_n = 1'b1;
      while (SSP_En === 1'b1 && drop_cyc < 10) begin
        @(negedge Clk);
        drop_cyc++;
      end
      wait_clk(4 * HALF);
    end
    d_eoc  = eoc_cnt - e0;
    d_ferr = ferr_cnt - f0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] w, input int nbits,
                             input logic [11:0] do_val, input logic [2:0] e_ra,
                             input logic e_wnr, input logic [11:0] e_di);
    logic [17:0] em, ee;
    em = '0; ee = '0;
    for (int k = 5; k <= nbits && k <= 16; k++) begin
      em[k-1] = do_val[16-k];
      ee[k-1] = 1'b1;
    end
    chk({tag, "_ra"}, 32'(SSP_RA), 32'(e_ra));
    chk({tag, "_wnr"}, 32'(SSP_WnR), 32'(e_wnr));
    chk({tag, "_di"}, 32'(SSP_DI), 32'(e_di));
    chk({tag, "_eoc_pulses"}, d_eoc, (nbits >= 16) ? 1 : 0);
    chk({tag, "_ferr_pulses"}, d_ferr, (ERR_EN && nbits != 16) ? 1 : 0);
    chk({tag, "_miso_bits"}, 32'(miso_cap), 32'(em));
    chk({tag, "_en_bits"}, 32'(en_cap), 32'(ee));
    chk({tag, "_oe_sel"}, 32'(oe_mid), 32'd1);
    chk({tag, "_oe_after"}, 32'(MISO_OE), 32'd0);
    chk({tag, "_en_after"}, 32'(SSP_En), 32'd0);
    $display("frame %s w=0x%04h bits=%0d do=0x%03h ra=%0d wnr=%0b di=0x%03h eoc=%0d ferr=%0d",
             tag, w, nbits, do_val, SSP_RA, SSP_WnR, SSP_DI, d_eoc, d_ferr);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [11:0] do_val;
    logic [2:0]  exp_ra;
    logic        exp_wnr;
    logic [11:0] exp_di;
  } vec_t;

  vec_t vecs[5];
  logic [2:0]  m_ra;
  logic        m_wnr;
  logic [11:0] m_di;

  initial begin
    int e0, f0, nb;
    logic [15:0] rw;
    logic [11:0] rd;

    vecs[0] = '{16'hA5C3, 12'h000, 3'd5, 1'b0, 12'h5C3};
    vecs[1] = '{16'h3000, 12'hB6E, 3'd1, 1'b1, 12'h000};
    vecs[2] = '{16'hF123, 12'h7E1, 3'd7, 1'b1, 12'h123};
    vecs[3] = '{16'h1FFF, 12'h001, 3'd0, 1'b1, 12'hFFF};
    vecs[4] = '{16'h8E5A, 12'h5A5, 3'd4, 1'b0, 12'hE5A};

    // Reset state
    wait_clk(4);
    chk("reset_outputs", {MISO, MISO_OE, SSP_SSEL, SSP_SCK, SSP_RA, SSP_WnR, SSP_En,
                          SSP_EOC, SSP_DI, Frame_Err}, 32'd0);
    Rst = 1'b1;
    wait_clk(8);

    foreach (vecs[i]) begin
      run_frame(vecs[i].w, 16, vecs[i].do_val, 1'b0);
      check_frame($sformatf("vec%0d", i), vecs[i].w, 16, vecs[i].do_val,
                  vecs[i].exp_ra, vecs[i].exp_wnr, vecs[i].exp_di);
      m_ra = vecs[i].exp_ra; m_wnr = vecs[i].exp_wnr; m_di = vecs[i].exp_di;
    end

    // Abort after 9 bits: RA/WnR updated, DI kept
    run_frame(16'hC9A7, 9, 12'h0F0, 1'b0);
    check_frame("abort9", 16'hC9A7, 9, 12'h0F0, 3'd6, 1'b0, m_di);
    chk("abort9_en_drop_fast", 32'(drop_cyc <= SYNC_STAGES + 2), 32'd1);
    m_ra = 3'd6; m_wnr = 1'b0;

    // Overlong: 18 rises in one select
    run_frame(16'h6D5B, 18, 12'h3C3, 1'b0);
    check_frame("overlong18", 16'h6D5B, 18, 12'h3C3, 3'd3, 1'b0, 12'hD5B);
    m_ra = 3'd3; m_wnr = 1'b0; m_di = 12'hD5B;

    // SCK activity while deselected
    e0 = eoc_cnt; f0 = ferr_cnt;
    for (int k = 0; k < 3; k++) begin
      SCK = 1'b1; wait_clk(HALF);
      if (k == 0) chk("idle_ssp_sck_high", 32'(SSP_SCK), 32'd1);
      SCK = 1'b0; wait_clk(HALF);
    end
    chk("idle_sck_no_activity", {SSP_En, SSP_SSEL, MISO_OE}, 32'd0);
    chk("idle_sck_no_strobes", (eoc_cnt - e0) + (ferr_cnt - f0), 32'd0);
    chk("idle_sck_regs_kept", {SSP_RA, SSP_WnR, SSP_DI}, {m_ra, m_wnr, m_di});
    $display("frame idle_sck ssp_sck=%0b en=%0b", SSP_SCK, SSP_En);

    // Randomized frames against the behavioural model
    for (int n = 0; n < 24; n++) begin
      rw = 16'($urandom);
      rd = 12'($urandom);
      nb = (n < 4) ? 16 : int'($urandom_range(1, 18));
      run_frame(rw, nb, rd, 1'b0);
      if (nb >= 3) m_ra = rw[15:13];
      if (nb >= 4) m_wnr = rw[12];
      if (nb >= 16) m_di = rw[11:0];
      check_frame($sformatf("rnd%0d", n), rw, nb, rd, m_ra, m_wnr, m_di);
    end

    // Reset pulse mid-DATA, then a clean frame
    run_frame(16'h9ABC, 8, 12'h321, 1'b1);
    e0 = eoc_cnt;
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    chk("midreset_outputs", {MISO, MISO_OE, SSP_SSEL, SSP_SCK, SSP_RA, SSP_WnR, SSP_En,
                             SSP_EOC, SSP_DI, Frame_Err}, 32'd0);
    wait_clk(6);
    SSEL_n = 1'b1;
    wait_clk(4 * HALF);
    chk("midreset_no_eoc", eoc_cnt - e0, 32'd0);
    $display("frame midreset di=0x%03h eoc_delta=%0d", SSP_DI, eoc_cnt - e0);
    run_frame(16'h4321, 16, 12'hABC, 1'b0);
    check_frame("after_reset", 16'h4321, 16, 12'hABC, 3'd2, 1'b0, 12'h321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
